// File: rtl/fdiv_arbiter.sv
// Round-robin arbiter that shares one iterative FP divider among N requesters.
// A watchdog turns a divide that never completes (divide by zero) into an error response.
module fdiv_arbiter #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [31:0]       rsp_q,
  output logic              rsp_err,
  output logic              busy,
  output logic              div_start,
  output logic [31:0]       div_a,
  output logic [31:0]       div_b,
  input  logic [31:0]       div_q,
  input  logic              div_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ID_W-1:0]   rr_ptr_r, gnt_id_r, gnt_idx_s, cand_s;
  logic [ID_W:0]     sum_s;
  logic              gnt_found_s, hit_s, timeout_s;
  logic [31:0]       sel_a_s, sel_b_s;
  logic [TW-1:0]     timer_r;
  logic [N-1:0]      req_ready_r;
  logic              rsp_valid_r, rsp_err_r, busy_r, div_start_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [31:0]       rsp_q_r, div_a_r, div_b_r;

  // Signed infinity returned when the watchdog aborts a divide.
  function automatic logic [31:0] abort_q(input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[31], 8'hFF, 23'h000000};
  endfunction

  assign timeout_s = (timer_r == TW'(TIMEOUT - 1));

  // Round-robin search starting at rr_ptr, wrapping modulo N.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {ID_W{1'b0}};
    sum_s       = {(ID_W+1){1'b0}};
    cand_s      = {ID_W{1'b0}};
    hit_s       = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s       = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      cand_s      = (sum_s >= (ID_W+1)'(N)) ? ID_W'(sum_s - (ID_W+1)'(N)) : sum_s[ID_W-1:0];
      hit_s       = req_valid[cand_s] & ~gnt_found_s;
      gnt_idx_s   = hit_s ? cand_s : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_s;
    end
    sel_a_s = req_a[{gnt_idx_s, 5'd0} +: 32];
    sel_b_s = req_b[{gnt_idx_s, 5'd0} +: 32];
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = gnt_found_s ? ISSUE : IDLE;
      ISSUE:   state_s = WAIT;
      WAIT:    state_s = (div_valid || timeout_s) ? RESP : WAIT;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs; pulses are set on the transition into their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= {ID_W{1'b0}};
      gnt_id_r    <= {ID_W{1'b0}};
      timer_r     <= {TW{1'b0}};
      req_ready_r <= {N{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_q_r     <= 32'h00000000;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      div_start_r <= 1'b0;
      div_a_r     <= 32'h00000000;
      div_b_r     <= 32'h00000000;
    end else begin
      req_ready_r <= {N{1'b0}};
      div_start_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (gnt_found_s) begin
            gnt_id_r    <= gnt_idx_s;
            div_a_r     <= sel_a_s;
            div_b_r     <= sel_b_s;
            req_ready_r <= {{(N-1){1'b0}}, 1'b1} << gnt_idx_s;
            div_start_r <= 1'b1;
          end
        end
        ISSUE: timer_r <= {TW{1'b0}};
        WAIT: begin
          timer_r <= timer_r + TW'(1);
          if (div_valid) begin
            rsp_q_r     <= div_q;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= gnt_id_r;
          end else if (timeout_s) begin
            rsp_q_r     <= abort_q(div_a_r, div_b_r);
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= gnt_id_r;
          end
        end
        RESP: rr_ptr_r <= (gnt_id_r == ID_W'(N - 1)) ? {ID_W{1'b0}} : gnt_id_r + ID_W'(1);
        default: ;
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_q     = rsp_q_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign div_start = div_start_r;
  assign div_a     = div_a_r;
  assign div_b     = div_b_r;

endmodule
